// File: rtl/ysyx_23060171_gpr_arb.sv
// ysyx_23060171_gpr_arb
//   Arbitrates GPR write-back between the EXU (req0) and the LSU (req1) and
//   tracks which destination registers still have a write outstanding.
//   - One write per cycle is accepted. A lone requester wins at once. When
//     both request, the one not granted most recently wins.
//   - The accepted write is registered onto gpr_wen/gpr_waddr/gpr_wdata.
//   - Writes to x0 are accepted but are never driven onto the GPR port.
//   - A busy bit per register is set on issue and cleared when the write
//     commits. hazard reports whether either source operand is still busy.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req0_valid/ready/addr/data    EXU write-back request (ready is combinational)
//   req1_valid/ready/addr/data    LSU write-back request (ready is combinational)
//   gpr_wen/gpr_waddr/gpr_wdata   registered GPR write port
//   iss_valid, iss_rd             issue: marks iss_rd pending
//   chk_raddr1, chk_raddr2        source operands to check
//   hazard                        combinational: a source operand is pending
//
// Optional feature (macro YSYX_23060171_GPR_ARB_BYPASS_EN)
//   Adds fwd_hit1/fwd_hit2 and fwd_data1/fwd_data2. A source that matches the
//   write on the GPR port this cycle is forwarded and no longer counts toward
//   hazard.

module ysyx_23060171_gpr_arb #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,

  output logic                  gpr_wen,
  output logic [ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0] gpr_wdata,

  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,

  input  logic [ADDR_WIDTH-1:0] chk_raddr1,
  input  logic [ADDR_WIDTH-1:0] chk_raddr2,
`ifdef YSYX_23060171_GPR_ARB_BYPASS_EN
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic [DATA_WIDTH-1:0] fwd_data2,
`endif
  output logic                  hazard
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

  // Round-robin pointer: names the requester that wins a tie.
  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } pri_e;

  pri_e                  pri_q;
  pri_e                  pri_d;
  logic                  grant0_c;
  logic                  grant1_c;
  logic                  wr_en_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic                  src1_busy_c;
  logic                  src2_busy_c;

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri_q <= PRI_REQ0;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Grant selection and pointer update. Ready is the grant itself, so every
  // grant is a transfer and the pointer moves only on a transfer.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    pri_d    = pri_q;
    if (!rst) begin
      unique case ({req1_valid, req0_valid})
        2'b01:   grant0_c = 1'b1;
        2'b10:   grant1_c = 1'b1;
        2'b11: begin
          if (pri_q == PRI_REQ0) grant0_c = 1'b1;
          else                   grant1_c = 1'b1;
        end
        default: ;
      endcase
    end
    if (grant0_c) begin
      pri_d = PRI_REQ1;
    end else if (grant1_c) begin
      pri_d = PRI_REQ0;
    end
  end

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;

  // Winning payload; an x0 target is swallowed here.
  always_comb begin
    wr_addr_c = grant1_c ? req1_addr : req0_addr;
    wr_data_c = grant1_c ? req1_data : req0_data;
    wr_en_c   = (grant0_c || grant1_c) && (wr_addr_c != ADDR_WIDTH'(0));
  end

  // GPR write port; address/data only move on a real write so they hold
  // their last value while gpr_wen is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else begin
      gpr_wen <= wr_en_c;
      if (wr_en_c) begin
        gpr_waddr <= wr_addr_c;
        gpr_wdata <= wr_data_c;
      end
    end
  end

  // Busy-bit update: the commit clears first so a same-edge issue to the
  // same register leaves it busy. x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (gpr_wen) begin
      busy_d[gpr_waddr] = 1'b0;
    end
    if (iss_valid && (iss_rd != ADDR_WIDTH'(0))) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy-bit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign src1_busy_c = busy_q[chk_raddr1];
  assign src2_busy_c = busy_q[chk_raddr2];

`ifdef YSYX_23060171_GPR_ARB_BYPASS_EN
  // Forward the write on the GPR port to a matching source operand.
  always_comb begin
    fwd_hit1  = gpr_wen && (gpr_waddr == chk_raddr1) && (chk_raddr1 != ADDR_WIDTH'(0));
    fwd_hit2  = gpr_wen && (gpr_waddr == chk_raddr2) && (chk_raddr2 != ADDR_WIDTH'(0));
    fwd_data1 = gpr_wdata;
    fwd_data2 = gpr_wdata;
    hazard    = (src1_busy_c && !fwd_hit1) || (src2_busy_c && !fwd_hit2);
  end
`else
  assign hazard = src1_busy_c || src2_busy_c;
`endif

endmodule

// File: tb/tb_ysyx_23060171_gpr_arb.sv
// Testbench for ysyx_23060171_gpr_arb: directed vectors, with expected GPR
// writes queued at issue time and popped by a separate write monitor.

module tb_ysyx_23060171_gpr_arb;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
`ifdef YSYX_23060171_GPR_ARB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0;
  logic          req0_ready;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req1_valid = 1'b0;
  logic          req1_ready;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic          gpr_wen;
  logic [AW-1:0] gpr_waddr;
  logic [DW-1:0] gpr_wdata;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_rd = '0;
  logic [AW-1:0] chk_raddr1 = '0;
  logic [AW-1:0] chk_raddr2 = '0;
  logic          hazard;
`ifdef YSYX_23060171_GPR_ARB_BYPASS_EN
  logic          fwd_hit1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_data1;
  logic [DW-1:0] fwd_data2;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  ysyx_23060171_gpr_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .gpr_wen    (gpr_wen),
    .gpr_waddr  (gpr_waddr),
    .gpr_wdata  (gpr_wdata),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .chk_raddr1 (chk_raddr1),
    .chk_raddr2 (chk_raddr2),
`ifdef YSYX_23060171_GPR_ARB_BYPASS_EN
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2),
`endif
    .hazard     (hazard)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Write monitor: every GPR write must match the oldest expected write.
  always @(negedge clk) begin
    if (gpr_wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none", gpr_waddr, gpr_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("mon_waddr", 32'(gpr_waddr), 32'(w.addr));
        check("mon_wdata", gpr_wdata, w.data);
      end
    end
  end

  initial begin
    // Reset state, ready held low during reset.
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_wen", 32'(gpr_wen), 32'd0);
    check("rst_waddr", 32'(gpr_waddr), 32'd0);
    check("rst_wdata", gpr_wdata, 32'd0);
    check("rst_hazard", 32'(hazard), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b0;

    // Issue x5, see hazard, commit 0xDEADBEEF, hazard clears.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd5;
    @(negedge clk);
    iss_valid = 1'b0; chk_raddr1 = 5'd5;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    check("t1_hazard_set", 32'(hazard), 32'd1);
    check("t1_ready0", 32'(req0_ready), 32'd1);
    check("t1_ready1", 32'(req1_ready), 32'd0);
    push(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("t1_wen", 32'(gpr_wen), 32'd1);
    check("t1_waddr", 32'(gpr_waddr), 32'd5);
    check("t1_wdata", gpr_wdata, 32'hDEADBEEF);
    check("t1_hazard_wen_cycle", 32'(hazard), 32'(!BYP));
    @(negedge clk);
    #1;
    check("t1_hazard_clear", 32'(hazard), 32'd0);
    check("t1_wen_low", 32'(gpr_wen), 32'd0);
    check("t1_waddr_hold", 32'(gpr_waddr), 32'd5);

    // Lone req1 wins immediately; pointer then favours req0.
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
    #1;
    check("t2_single_ready1", 32'(req1_ready), 32'd1);
    check("t2_single_ready0", 32'(req0_ready), 32'd0);
    push(5'd9, 32'h99);
    @(negedge clk);
    req1_valid = 1'b0;

    // Both valid for 4 cycles: grants alternate req0,req1,req0,req1.
    for (int i = 0; i < 4; i++) begin
      logic w0;
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h100 + 32'(i);
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h200 + 32'(i);
      #1;
      w0 = (i % 2) == 0;
      check("t2_alt_ready0", 32'(req0_ready), 32'(w0));
      check("t2_alt_ready1", 32'(req1_ready), 32'(!w0));
      if (w0) push(5'd1, 32'h100 + 32'(i));
      else    push(5'd2, 32'h200 + 32'(i));
      if (i > 0) check("t2_wen_streak", 32'(gpr_wen), 32'd1);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("t2_wen_last", 32'(gpr_wen), 32'd1);
    @(negedge clk);
    #1;
    check("t2_wen_drop", 32'(gpr_wen), 32'd0);

    // Write to x0 accepted but dropped; issue to x0 ignored.
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    check("t3_ready1_x0", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0; iss_valid = 1'b0; chk_raddr1 = 5'd0;
    #1;
    check("t3_wen_x0", 32'(gpr_wen), 32'd0);
    check("t3_hazard_x0", 32'(hazard), 32'd0);
    check("t3_waddr_hold", 32'(gpr_waddr), 32'd2);
    check("t3_wdata_hold", gpr_wdata, 32'h203);

    // Same-edge issue and commit of x7 leaves x7 busy.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd7;
    @(negedge clk);
    iss_valid = 1'b0; chk_raddr1 = 5'd7;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
    #1;
    check("t4_hazard_pre", 32'(hazard), 32'd1);
    check("t4_ready0", 32'(req0_ready), 32'd1);
    push(5'd7, 32'h77);
    @(negedge clk);
    req0_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    check("t4_wen", 32'(gpr_wen), 32'd1);
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    check("t4_hazard_kept", 32'(hazard), 32'd1);
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h78;
    #1;
    check("t4_hazard_still", 32'(hazard), 32'd1);
    check("t4_ready1", 32'(req1_ready), 32'd1);
    push(5'd7, 32'h78);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check("t4_hazard_wen_cycle", 32'(hazard), 32'(!BYP));
    @(negedge clk);
    #1;
    check("t4_hazard_clear", 32'(hazard), 32'd0);

    // Reset right after an accept discards the write and busy bits.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd6; chk_raddr1 = 5'd6;
    @(negedge clk);
    iss_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'hAA;
    #1;
    check("t5_hazard_pre", 32'(hazard), 32'd1);
    check("t5_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_wen", 32'(gpr_wen), 32'd0);
    check("t5_rst_waddr", 32'(gpr_waddr), 32'd0);
    check("t5_rst_hazard", 32'(hazard), 32'd0);
    check("t5_rst_ready0", 32'(req0_ready), 32'd0);

    // Release: first edge accepts; pointer back to req0; x3 committed.
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h55;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h88;
    iss_valid = 1'b1; iss_rd = 5'd3;
    chk_raddr1 = 5'd0; chk_raddr2 = 5'd3;
    #1;
    check("t5_rel_wen", 32'(gpr_wen), 32'd0);
    check("t5_rel_ready0", 32'(req0_ready), 32'd1);
    check("t5_rel_ready1", 32'(req1_ready), 32'd0);
    push(5'd3, 32'h55);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; iss_valid = 1'b0;
    #1;
    check("t5_wen", 32'(gpr_wen), 32'd1);
    check("t5_hazard_wen_cycle", 32'(hazard), 32'(!BYP));
`ifdef YSYX_23060171_GPR_ARB_BYPASS_EN
    check("t5_fwd_hit2", 32'(fwd_hit2), 32'd1);
    check("t5_fwd_data2", fwd_data2, 32'h55);
    check("t5_fwd_hit1", 32'(fwd_hit1), 32'd0);
`endif
    @(negedge clk);
    #1;
    check("t5_hazard_clear", 32'(hazard), 32'd0);
    check("t5_wen_drop", 32'(gpr_wen), 32'd0);

    @(negedge clk);
    @(negedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060171_gpr_arb.md
YSYX_23060171_GPR_ARB -- requirements
Module: ysyx_23060171_gpr_arb

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 5, GPR index width; DATA_WIDTH, 32, GPR data width.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid in 1, req0_ready out 1, req0_addr in ADDR_WIDTH, req0_data in DATA_WIDTH: EXU write-back request.
REQ-005 SHALL have ports: req1_valid in 1, req1_ready out 1, req1_addr in ADDR_WIDTH, req1_data in DATA_WIDTH: LSU write-back request.
REQ-006 SHALL have ports: gpr_wen out 1, gpr_waddr out ADDR_WIDTH, gpr_wdata out DATA_WIDTH: registered drive of GPR write port.
REQ-007 SHALL have ports: iss_valid in 1, iss_rd in ADDR_WIDTH: instruction issue, marks rd pending.
REQ-008 SHALL have ports: chk_raddr1 in ADDR_WIDTH, chk_raddr2 in ADDR_WIDTH, hazard out 1: source-operand pending check.

Function
REQ-009 SHALL grant at most one requester per cycle; ready asserted combinationally only to the winner; transfer = valid&&ready.
REQ-010 SHALL arbitrate round-robin: single request wins immediately; on simultaneous requests, winner is the requester not granted most recently; pointer updates only on a transfer.
REQ-011 SHALL always accept a winner (no backpressure from GPR); sustained throughput one write per cycle.
REQ-012 SHALL register the transfer: gpr_wen/gpr_waddr/gpr_wdata valid exactly one cycle after the accepting edge, gpr_wen deasserted the following cycle unless another transfer occurred.
REQ-013 SHALL accept (ready=1) requests with addr 0 but never assert gpr_wen for them.
REQ-014 SHALL keep a busy bit per register (2**ADDR_WIDTH bits); iss_valid with iss_rd!=0 sets busy[iss_rd] at the next edge; iss_rd=0 ignored.
REQ-015 SHALL clear busy[gpr_waddr] at the edge ending a gpr_wen cycle.
REQ-016 SHALL, on same-edge set and clear of one register, leave it busy (set wins).
REQ-017 SHALL drive hazard = busy[chk_raddr1] | busy[chk_raddr2], combinational; busy[0] constantly 0.
REQ-018 SHALL hold gpr_waddr/gpr_wdata stable while gpr_wen=0 (last value retained).

Reset
REQ-019 SHALL on rst: gpr_wen=0, gpr_waddr=0, gpr_wdata=0, all busy bits=0, hazard=0, RR pointer favouring req0; effect immediate, independent of clk.
REQ-020 SHALL, on reset mid-transfer, discard the registered write (no gpr_wen after rst deasserts) and accept requests from the first edge after release.
REQ-021 SHALL keep req0_ready/req1_ready at 0 while rst is high.

Configuration
REQ-022 SHALL support macro YSYX_23060171_GPR_ARB_BYPASS_EN.
REQ-023 SHALL, with the macro defined, add outputs fwd_hit1/fwd_hit2 (1) and fwd_data1/fwd_data2 (DATA_WIDTH): hit when gpr_wen && gpr_waddr==chk_raddrN && chk_raddrN!=0, data = gpr_wdata; that source then excluded from hazard.
REQ-024 SHALL, without the macro, omit those ports and compute hazard per REQ-017 only.

Verification
REQ-025 SHALL verify: reset, then iss_valid rd=5; next cycle chk_raddr1=5 -> hazard=1; req0 addr5 data 0xDEADBEEF accepted -> next cycle gpr_wen=1 waddr=5 wdata=0xDEADBEEF; following cycle hazard=0.
REQ-026 SHALL verify: req0 and req1 valid every cycle for 4 cycles -> grants alternate req0,req1,req0,req1; gpr_wen high 4 consecutive cycles.
REQ-027 SHALL verify: req1 addr0 data 0x1234 -> req1_ready=1, gpr_wen stays 0; iss_rd=0 -> chk_raddr1=0 gives hazard=0.
REQ-028 SHALL verify: iss rd=7 in same cycle gpr_wen commits waddr=7 -> busy[7] remains 1, hazard=1 until the next commit to x7.
REQ-029 SHALL verify: rst asserted between accept and gpr_wen -> gpr_wen=0 immediately and after release, all hazard=0.
REQ-030 SHALL verify (macro on): gpr_wen waddr=3 wdata=0x55, chk_raddr2=3 -> fwd_hit2=1, fwd_data2=0x55, hazard=0.
